// File: rtl/pipeline_regfile.sv
// pipeline_regfile
//   Register file plus pending-write scoreboard for the pipelined core.
//   Reads are combinational. The single writeback port is bypassed to the read
//   ports in the same cycle. Each register has a busy bit that is set when an
//   instruction issues with that register as its destination, and cleared at
//   writeback. The decode stage stalls on Hazard, which covers both RAW hazards
//   (a used operand is busy) and WAW hazards (the issuing destination is busy).
//
// Ports
//   Clock       in   rising-edge clock
//   Reset       in   asynchronous active-low reset
//   Enable      in   0 freezes all state (pipeline stall)
//   RdAddr      in   NUM_READ packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   RdUse       in   per-port flag: operand needed this cycle
//   RdData      out  NUM_READ packed read data, port i at [i*WORD_SIZE +: WORD_SIZE]
//   RdBusy      out  per-port flag: register has an outstanding write
//   IssueValid  in   instruction issuing with destination IssueDst
//   IssueDst    in   destination register to mark pending
//   IssueReady  out  destination has no pending write (or is written back now)
//   WbValid     in   writeback this cycle
//   WbAddr      in   writeback register
//   WbData      in   writeback data
//   Hazard      out  stall request to decode

module pipeline_regfile #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 8,
  parameter int NUM_READ  = 2,
  parameter int REG0_ZERO = 0,
  localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic [NUM_READ*ADDR_W-1:0]    RdAddr,
  input  logic [NUM_READ-1:0]           RdUse,
  output logic [NUM_READ*WORD_SIZE-1:0] RdData,
  output logic [NUM_READ-1:0]           RdBusy,
  input  logic                          IssueValid,
  input  logic [ADDR_W-1:0]             IssueDst,
  output logic                          IssueReady,
  input  logic                          WbValid,
  input  logic [ADDR_W-1:0]             WbAddr,
  input  logic [WORD_SIZE-1:0]          WbData,
  output logic                          Hazard
);

  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
  logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_d;

  logic [NUM_REGS-1:0]  wb_hot;
  logic [NUM_REGS-1:0]  iss_hot;
  logic [NUM_REGS-1:0]  iss_fire_hot;

  // One-hot decode of a register address. Out-of-range addresses and the
  // hard-wired zero register decode to all zeros, so every lookup through this
  // decode reads 0, reports not busy, and is never written or marked busy.
  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] dec;
    dec = '0;
    for (int j = 0; j < NUM_REGS; j++) begin
      if ((a == ADDR_W'(j)) && !((REG0_ZERO != 0) && (j == 0))) begin
        dec[j] = 1'b1;
      end
    end
    return dec;
  endfunction

  // Writeback hit vector. It is gated by Reset so the bypass cannot leak
  // WbData onto RdData while reset is held.
  always_comb begin
    wb_hot = '0;
    if (Reset && Enable && WbValid) begin
      wb_hot = decode(WbAddr);
    end
  end

  assign iss_hot    = decode(IssueDst);
  assign IssueReady = ~(|(iss_hot & busy_q)) | (|(iss_hot & wb_hot));

  always_comb begin
    iss_fire_hot = '0;
    if (Enable && IssueValid && IssueReady) begin
      iss_fire_hot = iss_hot;
    end
  end

  // When an issue and a writeback target the same register, the set wins.
  // That register then stays busy for the newly issued instruction.
  assign busy_d = (busy_q & ~wb_hot) | iss_fire_hot;

  always_comb begin
    for (int j = 0; j < NUM_REGS; j++) begin
      regs_d[j] = wb_hot[j] ? WbData : regs_q[j];
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int j = 0; j < NUM_REGS; j++) begin
        regs_q[j] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int j = 0; j < NUM_REGS; j++) begin
        regs_q[j] <= regs_d[j];
      end
      busy_q <= busy_d;
    end
  end

  // Read ports: mux the stored value, then override it with WbData on a
  // bypass hit. A bypass hit also hides the busy bit the writeback is clearing.
  always_comb begin
    logic [NUM_REGS-1:0]  sel;
    logic [WORD_SIZE-1:0] word;
    RdData = '0;
    RdBusy = '0;
    sel    = '0;
    word   = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      sel  = decode(RdAddr[i*ADDR_W +: ADDR_W]);
      word = '0;
      for (int j = 0; j < NUM_REGS; j++) begin
        if (sel[j]) begin
          word = regs_q[j];
        end
      end
      if (|(sel & wb_hot)) begin
        word = WbData;
      end
      RdData[i*WORD_SIZE +: WORD_SIZE] = word;
      RdBusy[i] = |(sel & busy_q & ~wb_hot);
    end
  end

  assign Hazard = (|(RdBusy & RdUse)) | (IssueValid & ~IssueReady);

endmodule

// File: tb/tb_pipeline_regfile.sv
module tb_pipeline_regfile;
  localparam int WS  = 16;
  localparam int NR  = 8;
  localparam int NRD = 2;
  localparam int AW  = 3;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              Enable;
  logic [NRD*AW-1:0] RdAddr;
  logic [NRD-1:0]    RdUse;
  logic [NRD*WS-1:0] RdData;
  logic [NRD-1:0]    RdBusy;
  logic              IssueValid;
  logic [AW-1:0]     IssueDst;
  logic              IssueReady;
  logic              WbValid;
  logic [AW-1:0]     WbAddr;
  logic [WS-1:0]     WbData;
  logic              Hazard;

  always #5 Clock = ~Clock;

  pipeline_regfile #(
    .WORD_SIZE(WS), .NUM_REGS(NR), .NUM_READ(NRD), .REG0_ZERO(1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable),
    .RdAddr(RdAddr), .RdUse(RdUse), .RdData(RdData), .RdBusy(RdBusy),
    .IssueValid(IssueValid), .IssueDst(IssueDst), .IssueReady(IssueReady),
    .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData), .Hazard(Hazard)
  );

  typedef struct {
    string       name;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  busy;
    logic        ir;
    logic        hz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, got, want);
    end
  endtask

  // Monitor: the outputs are combinational, so each cycle's entry is compared
  // at the falling edge, well away from the rising edge that updates state.
  initial begin
    forever begin
      @(negedge Clock);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk(e.name, "rd0",   {16'h0, RdData[15:0]},  {16'h0, e.d0});
        chk(e.name, "rd1",   {16'h0, RdData[31:16]}, {16'h0, e.d1});
        chk(e.name, "busy",  {30'h0, RdBusy},        {30'h0, e.busy});
        chk(e.name, "ready", {31'h0, IssueReady},    {31'h0, e.ir});
        chk(e.name, "hazard",{31'h0, Hazard},        {31'h0, e.hz});
      end
    end
  end

  task automatic drv(input logic en, input logic [2:0] a0, input logic [2:0] a1,
                     input logic [1:0] u, input logic iv, input logic [2:0] idst,
                     input logic wv, input logic [2:0] wa, input logic [15:0] wd);
    Enable     = en;
    RdAddr     = {a1, a0};
    RdUse      = u;
    IssueValid = iv;
    IssueDst   = idst;
    WbValid    = wv;
    WbAddr     = wa;
    WbData     = wd;
  endtask

  task automatic exp_push(input string nm, input logic [15:0] d0, input logic [15:0] d1,
                          input logic [1:0] bz, input logic ir, input logic hz);
    exp_t e;
    e.name = nm; e.d0 = d0; e.d1 = d1; e.busy = bz; e.ir = ir; e.hz = hz;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held: writes, issues and bypass are all suppressed.
    Reset = 1'b0;
    drv(1, 3, 0, 2'b11, 1, 3, 1, 3, 16'hDEAD);
    exp_push("rst_hold", 16'h0, 16'h0, 2'b00, 1, 0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;

    // 1: every register reads zero and idle after reset
    for (int k = 0; k < 4; k++) begin
      drv(1, 3'(2*k), 3'(2*k+1), 2'b11, 0, 3'(2*k), 0, 0, 16'h0);
      exp_push("t1_read", 16'h0, 16'h0, 2'b00, 1, 0);
      tick();
    end

    // 2: write, then read back; same-cycle bypass on port 1
    drv(1, 0, 1, 2'b00, 0, 0, 1, 3, 16'hBEEF);
    exp_push("t2_wr3", 16'h0, 16'h0, 2'b00, 1, 0);
    tick();
    drv(1, 3, 5, 2'b00, 0, 0, 1, 5, 16'h1234);
    exp_push("t2_bypass", 16'hBEEF, 16'h1234, 2'b00, 1, 0);
    tick();
    drv(1, 3, 5, 2'b00, 0, 0, 0, 0, 16'h0);
    exp_push("t2_rd", 16'hBEEF, 16'h1234, 2'b00, 1, 0);
    tick();

    // 3: issue r2, RAW and WAW hazards, then writeback clears busy
    drv(1, 2, 3, 2'b00, 1, 2, 0, 0, 16'h0);
    exp_push("t3_issue", 16'h0, 16'hBEEF, 2'b00, 1, 0);
    tick();
    drv(1, 2, 3, 2'b01, 0, 2, 0, 0, 16'h0);
    exp_push("t3_raw", 16'h0, 16'hBEEF, 2'b01, 0, 1);
    tick();
    drv(1, 2, 3, 2'b00, 1, 2, 0, 0, 16'h0);
    exp_push("t3_waw", 16'h0, 16'hBEEF, 2'b01, 0, 1);
    tick();
    drv(1, 2, 3, 2'b01, 0, 2, 1, 2, 16'h00AA);
    exp_push("t3_wb", 16'h00AA, 16'hBEEF, 2'b00, 1, 0);
    tick();
    drv(1, 2, 3, 2'b01, 0, 2, 0, 0, 16'h0);
    exp_push("t3_clr", 16'h00AA, 16'hBEEF, 2'b00, 1, 0);
    tick();

    // 4: same-cycle issue and writeback to r4: data written, busy stays set
    drv(1, 4, 2, 2'b00, 1, 4, 1, 4, 16'h5555);
    exp_push("t4_same", 16'h5555, 16'h00AA, 2'b00, 1, 0);
    tick();
    drv(1, 4, 2, 2'b01, 0, 4, 0, 0, 16'h0);
    exp_push("t4_after", 16'h5555, 16'h00AA, 2'b01, 0, 1);
    tick();

    // 5: Enable low freezes state and turns the bypass off
    drv(0, 1, 4, 2'b00, 1, 1, 1, 1, 16'hFFFF);
    exp_push("t5_frozen", 16'h0, 16'h5555, 2'b10, 1, 0);
    tick();
    drv(1, 1, 4, 2'b01, 0, 1, 0, 0, 16'h0);
    exp_push("t5_after", 16'h0, 16'h5555, 2'b10, 1, 0);
    tick();
    drv(0, 4, 1, 2'b01, 0, 4, 1, 4, 16'h7777);
    exp_push("t5_nobyp", 16'h5555, 16'h0, 2'b01, 0, 1);
    tick();
    drv(1, 4, 1, 2'b01, 0, 4, 1, 4, 16'h0404);
    exp_push("t5_wb4", 16'h0404, 16'h0, 2'b00, 1, 0);
    tick();
    drv(1, 4, 1, 2'b01, 0, 4, 0, 0, 16'h0);
    exp_push("t5_r4", 16'h0404, 16'h0, 2'b00, 1, 0);
    tick();

    // 6: r0 is hard-wired zero; then async reset drops a pending busy bit
    drv(1, 0, 6, 2'b11, 1, 0, 1, 0, 16'h1111);
    exp_push("t6_r0", 16'h0, 16'h0, 2'b00, 1, 0);
    tick();
    drv(1, 0, 6, 2'b01, 0, 0, 0, 0, 16'h0);
    exp_push("t6_r0_after", 16'h0, 16'h0, 2'b00, 1, 0);
    tick();
    drv(1, 6, 0, 2'b00, 1, 6, 0, 0, 16'h0);
    exp_push("t6_issue6", 16'h0, 16'h0, 2'b00, 1, 0);
    tick();
    drv(1, 6, 3, 2'b01, 0, 6, 0, 0, 16'h0);
    exp_push("t6_busy6", 16'h0, 16'hBEEF, 2'b01, 0, 1);
    tick();
    // Reset asserted between edges; the check falls before the next rising edge.
    Reset = 1'b0;
    exp_push("t6_rst_now", 16'h0, 16'h0, 2'b00, 1, 0);
    tick();
    Reset = 1'b1;
    drv(1, 6, 3, 2'b01, 0, 6, 0, 0, 16'h0);
    exp_push("t6_post", 16'h0, 16'h0, 2'b00, 1, 0);
    tick();

    drv(1, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0);
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      @(posedge Clock);
    end
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain %0d entries still queued, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
